// File: rtl/wb_ctrl.sv
// ---------------------------------------------------------------------------
// wb_ctrl -- writeback controller for the register file's single write port.
//
// Two result streams are merged into one registered write per cycle:
// ALU results, which are ready at once, and data-memory load returns, which
// arrive LD_LAT cycles after issue. ALU results that lose arbitration wait in
// a small holding FIFO. A per-register busy scoreboard with kill logic keeps
// register writes in program order.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous active-high reset
//   alu_valid  in   ALU result presented this cycle
//   alu_ptr    in   ALU destination register
//   alu_data   in   ALU result data
//   alu_ready  out  holding FIFO not full; result accepted on valid && ready
//   ld_issue   in   load issued to memory this cycle
//   ld_ptr     in   load destination register
//   ld_ready   out  a load may issue this cycle
//   mem_rdata  in   load data, valid LD_LAT cycles after the accepted issue
//   busy       out  bit i set while a live load targets register i
//   rf_we      out  register-file write enable (registered)
//   rf_ptr_w   out  register-file write address (registered)
//   rf_di      out  register-file write data (registered)
// ---------------------------------------------------------------------------
module wb_ctrl #(
  parameter int PTR_W  = 2,
  parameter int DW     = 8,
  parameter int LD_LAT = 3,
  parameter int DEPTH  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 alu_valid,
  input  logic [PTR_W-1:0]     alu_ptr,
  input  logic [DW-1:0]        alu_data,
  output logic                 alu_ready,
  input  logic                 ld_issue,
  input  logic [PTR_W-1:0]     ld_ptr,
  output logic                 ld_ready,
  input  logic [DW-1:0]        mem_rdata,
  output logic [2**PTR_W-1:0]  busy,
  output logic                 rf_we,
  output logic [PTR_W-1:0]     rf_ptr_w,
  output logic [DW-1:0]        rf_di
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Load tracking pipeline: stage LD_LAT-1 is the one returning this cycle.
  logic [LD_LAT-1:0] stg_valid;
  logic [LD_LAT-1:0] stg_live;
  logic [PTR_W-1:0]  stg_ptr [LD_LAT];

  // ALU holding FIFO.
  logic [DW-1:0]     fifo_data [DEPTH];
  logic [PTR_W-1:0]  fifo_ptr  [DEPTH];
  logic [AW-1:0]     wr_idx;
  logic [AW-1:0]     rd_idx;
  logic [CW-1:0]     count;

  logic live_return;
  logic fifo_empty;
  logic alu_acc;
  logic ld_acc;
  logic push;
  logic pop;

  assign live_return = stg_valid[LD_LAT-1] && stg_live[LD_LAT-1];
  assign fifo_empty  = (count == '0);
  assign alu_ready   = (count < CW'(DEPTH));
  // Holding loads back while ALU results are buffered guarantees an older
  // buffered ALU write can never land after a younger load's write.
  assign ld_ready    = fifo_empty && !live_return;
  assign alu_acc     = alu_valid && alu_ready;
  assign ld_acc      = ld_issue && ld_ready;
  // A live return owns the write port; otherwise the FIFO head drains first.
  assign pop         = !live_return && !fifo_empty;
  assign push        = alu_acc && (live_return || !fifo_empty);

  // A load still in flight is made dead when a younger write to the same
  // register is accepted this cycle. The returning stage is never killed:
  // it commits now and the younger write follows it.
  function automatic logic killed(input logic [PTR_W-1:0] p);
    return (alu_acc && (alu_ptr == p)) || (ld_acc && (ld_ptr == p));
  endfunction

  always_comb begin
    busy = '0;
    for (int i = 0; i < LD_LAT; i++) begin
      if (stg_valid[i] && stg_live[i]) begin
        busy[stg_ptr[i]] = 1'b1;
      end
    end
  end

  // Load pipeline shift; the new load enters live even when it targets the
  // same register as an ALU result accepted in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stg_valid <= '0;
      stg_live  <= '0;
      for (int i = 0; i < LD_LAT; i++) begin
        stg_ptr[i] <= '0;
      end
    end else begin
      stg_valid[0] <= ld_acc;
      stg_live[0]  <= ld_acc;
      stg_ptr[0]   <= ld_ptr;
      for (int i = 1; i < LD_LAT; i++) begin
        stg_valid[i] <= stg_valid[i-1];
        stg_live[i]  <= stg_live[i-1] && !killed(stg_ptr[i-1]);
        stg_ptr[i]   <= stg_ptr[i-1];
      end
    end
  end

  // FIFO pointers and occupancy; simultaneous push and pop keep the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_idx <= '0;
      rd_idx <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_idx <= wr_idx + 1'b1;
      end
      if (pop) begin
        rd_idx <= rd_idx + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_idx] <= alu_data;
      fifo_ptr[wr_idx]  <= alu_ptr;
    end
  end

  // Write arbitration: live return, then FIFO head, then ALU bypass.
  // Address and data hold their last values on idle cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_we    <= 1'b0;
      rf_ptr_w <= '0;
      rf_di    <= '0;
    end else if (live_return) begin
      rf_we    <= 1'b1;
      rf_ptr_w <= stg_ptr[LD_LAT-1];
      rf_di    <= mem_rdata;
    end else if (pop) begin
      rf_we    <= 1'b1;
      rf_ptr_w <= fifo_ptr[rd_idx];
      rf_di    <= fifo_data[rd_idx];
    end else if (alu_acc) begin
      rf_we    <= 1'b1;
      rf_ptr_w <= alu_ptr;
      rf_di    <= alu_data;
    end else begin
      rf_we    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wb_ctrl.sv
// ---------------------------------------------------------------------------
// tb_wb_ctrl -- self-checking bench for wb_ctrl.
//
// Directed vector table, hand-written saturation and mid-stream reset
// sequences, then randomized traffic compared cycle by cycle against a
// queue-based reference model plus an end-of-run program-order check of the
// register contents.
//
// Inputs are driven just after the falling edge and outputs sampled 1ns
// later, well away from the rising edge that the DUT uses.
// ---------------------------------------------------------------------------
module tb_wb_ctrl;

  localparam int PTR_W  = 2;
  localparam int DW     = 8;
  localparam int LD_LAT = 3;
  // With LD_LAT=3 at most three consecutive live returns can occur, so a
  // two-entry FIFO is what lets the bench actually reach the full condition.
  localparam int DEPTH  = 2;
  localparam int NREG   = 2**PTR_W;

  logic             clk = 1'b0;
  logic             reset;
  logic             alu_valid;
  logic [PTR_W-1:0] alu_ptr;
  logic [DW-1:0]    alu_data;
  logic             alu_ready;
  logic             ld_issue;
  logic [PTR_W-1:0] ld_ptr;
  logic             ld_ready;
  logic [DW-1:0]    mem_rdata;
  logic [NREG-1:0]  busy;
  logic             rf_we;
  logic [PTR_W-1:0] rf_ptr_w;
  logic [DW-1:0]    rf_di;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_ctrl #(
    .PTR_W (PTR_W),
    .DW    (DW),
    .LD_LAT(LD_LAT),
    .DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .alu_valid(alu_valid),
    .alu_ptr  (alu_ptr),
    .alu_data (alu_data),
    .alu_ready(alu_ready),
    .ld_issue (ld_issue),
    .ld_ptr   (ld_ptr),
    .ld_ready (ld_ready),
    .mem_rdata(mem_rdata),
    .busy     (busy),
    .rf_we    (rf_we),
    .rf_ptr_w (rf_ptr_w),
    .rf_di    (rf_di)
  );

  // Directed vector: inputs for one cycle and the outputs expected in it.
  typedef struct {
    logic             av;
    logic [PTR_W-1:0] ap;
    logic [DW-1:0]    ad;
    logic             li;
    logic [PTR_W-1:0] lp;
    logic [DW-1:0]    md;
    logic             we;
    logic [PTR_W-1:0] ptr;
    logic [DW-1:0]    di;
    logic [NREG-1:0]  bsy;
    logic             ldr;
    logic             alr;
  } vec_t;

  vec_t vecs[27];

  // Reference model state.
  typedef struct {
    int               due;
    logic [PTR_W-1:0] ptr;
    bit               live;
  } ld_t;

  ld_t                 ldq[$];
  logic [PTR_W+DW-1:0] fifoq[$];
  logic                m_we;
  logic [PTR_W-1:0]    m_ptr;
  logic [DW-1:0]       m_di;
  logic [DW-1:0]       arch[NREG];
  logic [DW-1:0]       seen[NREG];
  int                  cyc;

  function automatic vec_t mk(int av, int ap, int ad, int li, int lp, int md,
                              int we, int ptr, int di, int bsy, int ldr, int alr);
    vec_t v;
    v.av  = 1'(av);
    v.ap  = PTR_W'(ap);
    v.ad  = DW'(ad);
    v.li  = 1'(li);
    v.lp  = PTR_W'(lp);
    v.md  = DW'(md);
    v.we  = 1'(we);
    v.ptr = PTR_W'(ptr);
    v.di  = DW'(di);
    v.bsy = NREG'(bsy);
    v.ldr = 1'(ldr);
    v.alr = 1'(alr);
    return v;
  endfunction

  function automatic logic [DW-1:0] mem_val(int c);
    return DW'(c * 37 + 11);
  endfunction

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Drive one cycle's inputs after the falling edge, then settle.
  task automatic apply_stimulus(input int av, input int ap, input int ad,
                                input int li, input int lp, input int md);
    @(negedge clk);
    alu_valid = 1'(av);
    alu_ptr   = PTR_W'(ap);
    alu_data  = DW'(ad);
    ld_issue  = 1'(li);
    ld_ptr    = PTR_W'(lp);
    mem_rdata = DW'(md);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    alu_valid = 1'b0;
    alu_ptr   = '0;
    alu_data  = '0;
    ld_issue  = 1'b0;
    ld_ptr    = '0;
    mem_rdata = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic model_reset();
    ldq.delete();
    fifoq.delete();
    m_we  = 1'b0;
    m_ptr = '0;
    m_di  = '0;
    for (int i = 0; i < NREG; i++) begin
      arch[i] = '0;
      seen[i] = '0;
    end
    cyc = 0;
  endtask

  // One cycle of the reference model: compare, then advance using the
  // currently driven inputs. Loads are tracked by due cycle, not by stage.
  task automatic model_step();
    bit               lret;
    logic [PTR_W-1:0] rptr;
    logic [NREG-1:0]  ebusy;
    bit               a_acc;
    bit               l_acc;
    lret  = 0;
    rptr  = '0;
    ebusy = '0;
    check_output("rand rf_we", 32'(rf_we), 32'(m_we));
    check_output("rand rf_ptr_w", 32'(rf_ptr_w), 32'(m_ptr));
    check_output("rand rf_di", 32'(rf_di), 32'(m_di));
    if (rf_we) seen[rf_ptr_w] = rf_di;
    foreach (ldq[i]) begin
      if (ldq[i].live) ebusy[ldq[i].ptr] = 1'b1;
      if (ldq[i].due == cyc && ldq[i].live) begin
        lret = 1;
        rptr = ldq[i].ptr;
      end
    end
    check_output("rand busy", 32'(busy), 32'(ebusy));
    check_output("rand alu_ready", 32'(alu_ready), 32'(fifoq.size() < DEPTH));
    check_output("rand ld_ready", 32'(ld_ready), 32'(fifoq.size() == 0 && !lret));
    a_acc = alu_valid && (fifoq.size() < DEPTH);
    l_acc = ld_issue && (fifoq.size() == 0) && !lret;
    foreach (ldq[i]) begin
      if (ldq[i].due > cyc) begin
        if (a_acc && ldq[i].ptr == alu_ptr) ldq[i].live = 0;
        if (l_acc && ldq[i].ptr == ld_ptr) ldq[i].live = 0;
      end
    end
    if (lret) begin
      m_we  = 1'b1;
      m_ptr = rptr;
      m_di  = mem_rdata;
      if (a_acc) fifoq.push_back({alu_ptr, alu_data});
    end else if (fifoq.size() > 0) begin
      m_we = 1'b1;
      {m_ptr, m_di} = fifoq.pop_front();
      if (a_acc) fifoq.push_back({alu_ptr, alu_data});
    end else if (a_acc) begin
      m_we  = 1'b1;
      m_ptr = alu_ptr;
      m_di  = alu_data;
    end else begin
      m_we = 1'b0;
    end
    while (ldq.size() > 0 && ldq[0].due == cyc) void'(ldq.pop_front());
    if (l_acc) ldq.push_back('{cyc + LD_LAT, ld_ptr, 1'b1});
    // Program order: the ALU result is older than a same-cycle load.
    if (a_acc) arch[alu_ptr] = alu_data;
    if (l_acc) arch[ld_ptr] = mem_val(cyc + LD_LAT);
    cyc++;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [PTR_W+DW-1:0] got[$];
    logic [PTR_W+DW-1:0] exp_w[7];
    int idx;
    int stalls;
    int md;

    reset = 1'b1;
    do_reset();
    #1;
    check_output("reset rf_we", 32'(rf_we), 32'd0);
    check_output("reset rf_ptr_w", 32'(rf_ptr_w), 32'd0);
    check_output("reset rf_di", 32'(rf_di), 32'd0);
    check_output("reset busy", 32'(busy), 32'd0);
    check_output("reset alu_ready", 32'(alu_ready), 32'd1);
    check_output("reset ld_ready", 32'(ld_ready), 32'd1);

    // ---------------- directed vector table ----------------
    //              av ap ad    li lp md     we ptr di   bsy ldr alr
    vecs[0]  = mk(1, 2, 'h5A, 0, 0, 0,     0, 0, 'h00, 0, 1, 1);
    vecs[1]  = mk(0, 0, 0,    0, 0, 0,     1, 2, 'h5A, 0, 1, 1);
    vecs[2]  = mk(0, 0, 0,    1, 1, 0,     0, 2, 'h5A, 0, 1, 1);
    vecs[3]  = mk(0, 0, 0,    0, 0, 0,     0, 2, 'h5A, 2, 1, 1);
    vecs[4]  = mk(0, 0, 0,    0, 0, 0,     0, 2, 'h5A, 2, 1, 1);
    vecs[5]  = mk(0, 0, 0,    0, 0, 'hC3,  0, 2, 'h5A, 2, 0, 1);
    vecs[6]  = mk(0, 0, 0,    0, 0, 0,     1, 1, 'hC3, 0, 1, 1);
    vecs[7]  = mk(0, 0, 0,    1, 1, 0,     0, 1, 'hC3, 0, 1, 1);
    vecs[8]  = mk(0, 0, 0,    0, 0, 0,     0, 1, 'hC3, 2, 1, 1);
    vecs[9]  = mk(0, 0, 0,    0, 0, 0,     0, 1, 'hC3, 2, 1, 1);
    vecs[10] = mk(1, 3, 'h11, 0, 0, 'hC3,  0, 1, 'hC3, 2, 0, 1);
    vecs[11] = mk(1, 3, 'h22, 0, 0, 0,     1, 1, 'hC3, 0, 0, 1);
    vecs[12] = mk(0, 0, 0,    0, 0, 0,     1, 3, 'h11, 0, 0, 1);
    vecs[13] = mk(0, 0, 0,    0, 0, 0,     1, 3, 'h22, 0, 1, 1);
    vecs[14] = mk(0, 0, 0,    1, 0, 0,     0, 3, 'h22, 0, 1, 1);
    vecs[15] = mk(1, 0, 'h77, 0, 0, 0,     0, 3, 'h22, 1, 1, 1);
    vecs[16] = mk(0, 0, 0,    0, 0, 0,     1, 0, 'h77, 0, 1, 1);
    vecs[17] = mk(0, 0, 0,    0, 0, 0,     0, 0, 'h77, 0, 1, 1);
    vecs[18] = mk(0, 0, 0,    0, 0, 'hEE,  0, 0, 'h77, 0, 1, 1);
    vecs[19] = mk(0, 0, 0,    0, 0, 0,     0, 0, 'h77, 0, 1, 1);
    vecs[20] = mk(0, 0, 0,    1, 2, 0,     0, 0, 'h77, 0, 1, 1);
    vecs[21] = mk(0, 0, 0,    1, 2, 0,     0, 0, 'h77, 4, 1, 1);
    vecs[22] = mk(0, 0, 0,    0, 0, 0,     0, 0, 'h77, 4, 1, 1);
    vecs[23] = mk(0, 0, 0,    0, 0, 'hA1,  0, 0, 'h77, 4, 1, 1);
    vecs[24] = mk(0, 0, 0,    0, 0, 'hB2,  0, 0, 'h77, 4, 0, 1);
    vecs[25] = mk(0, 0, 0,    0, 0, 0,     1, 2, 'hB2, 0, 1, 1);
    vecs[26] = mk(0, 0, 0,    0, 0, 0,     0, 2, 'hB2, 0, 1, 1);

    for (int i = 0; i < 27; i++) begin
      apply_stimulus(int'(vecs[i].av), int'(vecs[i].ap), int'(vecs[i].ad),
                     int'(vecs[i].li), int'(vecs[i].lp), int'(vecs[i].md));
      check_output($sformatf("vec%0d rf_we", i), 32'(rf_we), 32'(vecs[i].we));
      check_output($sformatf("vec%0d rf_ptr_w", i), 32'(rf_ptr_w), 32'(vecs[i].ptr));
      check_output($sformatf("vec%0d rf_di", i), 32'(rf_di), 32'(vecs[i].di));
      check_output($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].bsy));
      check_output($sformatf("vec%0d ld_ready", i), 32'(ld_ready), 32'(vecs[i].ldr));
      check_output($sformatf("vec%0d alu_ready", i), 32'(alu_ready), 32'(vecs[i].alr));
    end

    // ---------------- saturation: live returns hold off FIFO drain --------
    do_reset();
    apply_stimulus(0, 0, 0, 1, 0, 0);
    apply_stimulus(0, 0, 0, 1, 1, 0);
    apply_stimulus(0, 0, 0, 1, 2, 0);
    exp_w = '{10'h0D0, 10'h1D1, 10'h2D2, 10'h310, 10'h311, 10'h312, 10'h313};
    got.delete();
    idx    = 0;
    stalls = 0;
    for (int k = 3; k < 40 && got.size() < 7; k++) begin
      md = (k == 3) ? 'hD0 : (k == 4) ? 'hD1 : (k == 5) ? 'hD2 : 0;
      apply_stimulus((idx < 4) ? 1 : 0, 3, 'h10 + idx, 0, 0, md);
      if (k == 3) check_output("sat busy", 32'(busy), 32'h7);
      if (rf_we) got.push_back({rf_ptr_w, rf_di});
      if (idx < 4) begin
        if (alu_ready) idx++;
        else stalls++;
      end
    end
    check_output("sat write count", 32'(got.size()), 32'd7);
    for (int i = 0; i < 7 && i < got.size(); i++) begin
      check_output($sformatf("sat write%0d", i), 32'(got[i]), 32'(exp_w[i]));
    end
    check_output("sat stall cycles", 32'(stalls), 32'd2);

    // ---------------- reset in the middle of traffic ----------------
    apply_stimulus(0, 0, 0, 1, 1, 0);
    apply_stimulus(1, 0, 'h55, 1, 2, 0);
    apply_stimulus(0, 0, 0, 0, 0, 0);
    check_output("midrst pre rf_we", 32'(rf_we), 32'd1);
    check_output("midrst pre rf_di", 32'(rf_di), 32'h55);
    check_output("midrst pre busy", 32'(busy), 32'h6);
    #1 reset = 1'b1;
    #1;
    check_output("midrst rf_we", 32'(rf_we), 32'd0);
    check_output("midrst rf_di", 32'(rf_di), 32'd0);
    check_output("midrst busy", 32'(busy), 32'd0);
    check_output("midrst ld_ready", 32'(ld_ready), 32'd1);
    check_output("midrst alu_ready", 32'(alu_ready), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    for (int j = 0; j < 4; j++) begin
      apply_stimulus(0, 0, 0, 0, 0, 'hF0 + j);
      check_output($sformatf("midrst late%0d rf_we", j), 32'(rf_we), 32'd0);
      check_output($sformatf("midrst late%0d busy", j), 32'(busy), 32'd0);
    end

    // ---------------- randomized traffic against the model ----------------
    do_reset();
    model_reset();
    for (int n = 0; n < 600; n++) begin
      apply_stimulus((($urandom % 3) != 0) ? 1 : 0, int'($urandom % NREG),
                     int'($urandom % 256), (($urandom % 5) < 3) ? 1 : 0,
                     int'($urandom % NREG), int'(mem_val(cyc)));
      model_step();
    end
    for (int n = 0; n < LD_LAT + DEPTH + 4; n++) begin
      apply_stimulus(0, 0, 0, 0, 0, int'(mem_val(cyc)));
      model_step();
    end
    for (int r = 0; r < NREG; r++) begin
      check_output($sformatf("final r%0d", r), 32'(seen[r]), 32'(arch[r]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
